sad_min_search: RTL and testbench
=================================

Name: sad_min_search

Overview:
- Pipelined, parametrised minimum-SAD search for the motion-estimation datapath.
- Each accepted beat carries N_CAND SADs for one search row. These are candidates mv_x = 0..N_CAND-1.
- A registered compare tree reduces each beat to its row minimum. A running accumulator then tracks the block minimum across ROWS beats and returns best_sad, best_mv_x and best_mv_y through a valid/ready output.

Parameters:
- SAD_W, 14, bit width of each SAD value.
- N_CAND, 16, candidates per beat; must be a power of two, at least 2.
- ROWS, 16, beats per search block; must be a power of two, at least 2.
- Derived values (localparam): XW = log2(N_CAND), YW = log2(ROWS), L = XW (number of tree levels).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pipeline, row counter and pending result.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- sad_in  in  N_CAND*SAD_W  packed SADs; candidate i occupies bits [i*SAD_W +: SAD_W].
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  result accepted when out_valid && out_ready.
- best_sad  out  SAD_W  block minimum SAD.
- best_mv_x  out  XW  candidate index of the minimum.
- best_mv_y  out  YW  row index of the minimum.

Behaviour:
- Reset (rst_n=0, async): all pipeline valids = 0, row counter = 0, out_valid = 0, best_sad/best_mv_x/best_mv_y = 0. in_ready = 1 once reset is released.
- Stall rule:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stall = 1, every pipeline register and the accumulator hold their contents.
- Row counter:
  - Increments on each accepted beat and wraps from ROWS-1 to 0.
  - The beat's row index (YW bits) and a last flag (row == ROWS-1) travel with it through the pipeline.
- Compare tree:
  - Level k pairs entries 2j and 2j+1. It keeps the value of entry 2j if v[2j] <= v[2j+1], otherwise the value of entry 2j+1.
  - The index grows by one MSB per level: 0 if the even entry won, 1 if the odd entry won.
  - Ties therefore resolve to the lower mv_x.
  - Every level is registered, so the row minimum is valid L cycles after the beat is accepted.
- Accumulator (one further cycle):
  - On the first row (row index 0), load the tree result unconditionally.
  - On any other row, replace the stored best only if the row SAD < stored SAD (strict). Earlier rows win ties.
  - On the last row, the updated best becomes the output and out_valid is set.
- Latency: out_valid rises L+1 cycles after acceptance of the last beat, assuming no stall.
- Output hand-off:
  - best_* is stable while out_valid = 1.
  - out_valid clears on out_valid && out_ready.
- Back-to-back blocks:
  - The first beat of the next block may be accepted in the cycle immediately after the last beat of the previous one.
  - If out_ready = 1 in the same cycle that a new result completes, the old result is accepted and replaced by the new one with no bubble.
- flush:
  - Takes priority over all other actions.
  - Clears pipeline valids, row counter, out_valid and accumulator to the reset state.
  - Beats presented in the flush cycle are discarded.
- Reset asserted mid-block: everything returns to the reset state asynchronously; no partial result is ever emitted.
- No arithmetic widening: all values are SAD_W bits, and comparisons are unsigned.

Optional Feature:
- Macro SAD_MIN_THRESH_EN.
- When defined:
  - Adds input thresh [SAD_W] and output below_thresh [1].
  - below_thresh is registered alongside best_sad as (final best_sad <= thresh), using thresh sampled in the cycle the last row reaches the accumulator.
  - below_thresh resets to 0 and is held with the result.
- When undefined: neither port exists, and there is no added logic or latency.

Test Plan:
- SAD_W=14, N_CAND=16, ROWS=4 (L=4).
  - Stimulus: four back-to-back beats, all SADs 500 except row 2, candidate 9 = 37.
  - Response: out_valid exactly 5 cycles after the 4th beat; best_sad=37, mv_x=9, mv_y=2.
- Tie handling.
  - Stimulus: row 1 has candidates 3 and 12 both = 10; row 3 has candidate 0 = 10; everything else is 0x3FFF.
  - Response: best_sad=10, mv_x=3, mv_y=1.
- Backpressure.
  - Stimulus: out_ready=0 when the result appears; drive further beats and hold for 6 cycles.
  - Response: in_ready=0 and outputs frozen. Once out_ready=1, the result is accepted and the next block's result is correct.
- Mid-block flush.
  - Stimulus: flush after 2 beats of a block, then a clean 4-beat block containing a single 0 at row 0, candidate 15.
  - Response: exactly one out_valid; best=(0,15,0).
- Asynchronous reset.
  - Stimulus: rst_n pulsed low between clock edges during block 3 of a stream.
  - Response: all outputs 0 immediately; no out_valid until a fresh 4-beat block completes.
- SAD_MIN_THRESH_EN.
  - Stimulus: thresh=40 with best=37, then a block with best=41.
  - Response: below_thresh = 1 for the first block, then 0 for the second.

Source files
------------

// File: rtl/sad_min_search.sv
// Pipelined minimum-SAD search: registered compare tree per row, then a block-wide running minimum.
// Optional threshold flag output is enabled by defining SAD_MIN_THRESH_EN.
module sad_min_search #(
    parameter int unsigned SAD_W  = 14,
    parameter int unsigned N_CAND = 16,
    parameter int unsigned ROWS   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_CAND*SAD_W-1:0]     sad_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SAD_W-1:0]            best_sad,
    output logic [$clog2(N_CAND)-1:0]   best_mv_x,
`ifdef SAD_MIN_THRESH_EN
    input  logic [SAD_W-1:0]            thresh,
    output logic                        below_thresh,
`endif
    output logic [$clog2(ROWS)-1:0]     best_mv_y
);

    localparam int unsigned XW = $clog2(N_CAND);
    localparam int unsigned YW = $clog2(ROWS);
    localparam int unsigned L  = XW;
    localparam int unsigned NN = N_CAND - 1;

    logic stall;
    logic en;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready && !flush;

    logic [YW-1:0]       row_cnt;
    logic [L-1:0]        vld;
    logic [L-1:0]        last_p;
    logic [YW-1:0]       row_p [L];
    logic [NN*SAD_W-1:0] node_val;
    logic [NN*SAD_W-1:0] nxt_val;
    logic [NN*XW-1:0]    node_idx;
    logic [NN*XW-1:0]    nxt_idx;

    // Tree nodes are packed level after level; level k occupies N_CAND>>k slots starting at BASE.
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int unsigned BASE = N_CAND - (N_CAND >> (k - 1));
        for (genvar j = 0; j < (N_CAND >> k); j++) begin : g_node
            logic [SAD_W-1:0] a;
            logic [SAD_W-1:0] b;
            logic [XW-1:0]    ia;
            logic [XW-1:0]    ib;
            logic             odd;
            if (k == 1) begin : g_leaf
                assign a  = sad_in[(2*j)*SAD_W +: SAD_W];
                assign b  = sad_in[(2*j+1)*SAD_W +: SAD_W];
                assign ia = '0;
                assign ib = '0;
            end else begin : g_int
                localparam int unsigned PBASE = BASE - (N_CAND >> (k - 1));
                assign a  = node_val[(PBASE+2*j)*SAD_W +: SAD_W];
                assign b  = node_val[(PBASE+2*j+1)*SAD_W +: SAD_W];
                assign ia = node_idx[(PBASE+2*j)*XW +: XW];
                assign ib = node_idx[(PBASE+2*j+1)*XW +: XW];
            end
            // Even entry wins ties, so equal SADs resolve to the lower mv_x.
            assign odd = a > b;
            assign nxt_val[(BASE+j)*SAD_W +: SAD_W] = odd ? b : a;
            assign nxt_idx[(BASE+j)*XW +: XW]       = (odd ? ib : ia) | (XW'(odd) << (k - 1));
        end
    end

    // Row counter, tree registers and per-stage side-band (valid, row, last).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt  <= '0;
            vld      <= '0;
            last_p   <= '0;
            node_val <= '0;
            node_idx <= '0;
            for (int unsigned s = 0; s < L; s++) row_p[s] <= '0;
        end else if (flush) begin
            row_cnt <= '0;
            vld     <= '0;
            last_p  <= '0;
        end else if (en) begin
            if (accept) row_cnt <= row_cnt + YW'(1);
            vld[0]    <= accept;
            last_p[0] <= (row_cnt == YW'(ROWS - 1));
            row_p[0]  <= row_cnt;
            for (int unsigned s = 1; s < L; s++) begin
                vld[s]    <= vld[s-1];
                last_p[s] <= last_p[s-1];
                row_p[s]  <= row_p[s-1];
            end
            node_val <= nxt_val;
            node_idx <= nxt_idx;
        end
    end

    logic [SAD_W-1:0] tree_val;
    logic [XW-1:0]    tree_idx;
    logic [SAD_W-1:0] acc_sad;
    logic [XW-1:0]    acc_x;
    logic [YW-1:0]    acc_y;
    logic             take;
    logic [SAD_W-1:0] new_sad;
    logic [XW-1:0]    new_x;
    logic [YW-1:0]    new_y;

    assign tree_val = node_val[(NN-1)*SAD_W +: SAD_W];
    assign tree_idx = node_idx[(NN-1)*XW +: XW];

    // First row loads unconditionally; later rows must be strictly smaller to replace.
    always_comb begin
        take    = 1'b0;
        new_sad = acc_sad;
        new_x   = acc_x;
        new_y   = acc_y;
        take    = (row_p[L-1] == '0) || (tree_val < acc_sad);
        if (take) begin
            new_sad = tree_val;
            new_x   = tree_idx;
            new_y   = row_p[L-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sad      <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            out_valid    <= 1'b0;
            best_sad     <= '0;
            best_mv_x    <= '0;
            best_mv_y    <= '0;
`ifdef SAD_MIN_THRESH_EN
            below_thresh <= 1'b0;
`endif
        end else if (flush) begin
            acc_sad      <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            out_valid    <= 1'b0;
            best_sad     <= '0;
            best_mv_x    <= '0;
            best_mv_y    <= '0;
`ifdef SAD_MIN_THRESH_EN
            below_thresh <= 1'b0;
`endif
        end else if (en) begin
            // Not stalled: any held result is being accepted this cycle.
            out_valid <= vld[L-1] && last_p[L-1];
            if (vld[L-1]) begin
                acc_sad <= new_sad;
                acc_x   <= new_x;
                acc_y   <= new_y;
                if (last_p[L-1]) begin
                    best_sad     <= new_sad;
                    best_mv_x    <= new_x;
                    best_mv_y    <= new_y;
`ifdef SAD_MIN_THRESH_EN
                    below_thresh <= (new_sad <= thresh);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_min_search.sv
// Directed self-checking bench for sad_min_search (SAD_W=14, N_CAND=16, ROWS=4).
// Threshold checks are compiled in when SAD_MIN_THRESH_EN is defined.
module tb_sad_min_search;

    localparam int unsigned SAD_W  = 14;
    localparam int unsigned N_CAND = 16;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned L      = 4;
    localparam int unsigned XW     = 4;
    localparam int unsigned YW     = 2;
    localparam int unsigned NW     = N_CAND * SAD_W;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [NW-1:0]    sad_in    = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SAD_W-1:0] best_sad;
    logic [XW-1:0]    best_mv_x;
    logic [YW-1:0]    best_mv_y;
`ifdef SAD_MIN_THRESH_EN
    logic [SAD_W-1:0] thresh    = 14'd40;
    logic             below_thresh;
`endif

    sad_min_search #(.SAD_W(SAD_W), .N_CAND(N_CAND), .ROWS(ROWS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sad_in       (sad_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .best_sad     (best_sad),
        .best_mv_x    (best_mv_x),
`ifdef SAD_MIN_THRESH_EN
        .thresh       (thresh),
        .below_thresh (below_thresh),
`endif
        .best_mv_y    (best_mv_y)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Handshake monitor: counts accepted results and keeps the last one.
    int               hs_cnt = 0;
    logic [SAD_W-1:0] hs_sad = '0;
    logic [XW-1:0]    hs_x   = '0;
    logic [YW-1:0]    hs_y   = '0;
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            hs_cnt = hs_cnt + 1;
            hs_sad = best_sad;
            hs_x   = best_mv_x;
            hs_y   = best_mv_y;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] mk(input logic [SAD_W-1:0] fill, input int c,
                                         input logic [SAD_W-1:0] v);
        logic [NW-1:0] b;
        for (int i = 0; i < int'(N_CAND); i++) b[i*SAD_W +: SAD_W] = (i == c) ? v : fill;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [NW-1:0] v);
        int n;
        n        = 0;
        in_valid = 1'b1;
        sad_in   = v;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_best(input string tag, input int s, input int x, input int y);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sad"}, best_sad, s);
        check({tag, "_mvx"}, best_mv_x, x);
        check({tag, "_mvy"}, best_mv_y, y);
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        logic [NW-1:0] b;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_best_sad", best_sad, 0);
        check("rst_mvx", best_mv_x, 0);
        check("rst_mvy", best_mv_y, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        // Basic block and latency: row 2 cand 9 = 37
        send_beat(mk(500, -1, 0));
        send_beat(mk(500, -1, 0));
        send_beat(mk(500, 9, 37));
        send_beat(mk(500, -1, 0));
        wait_out(lat);
        check("t1_latency", lat + 1, int'(L) + 1);
        check_best("t1", 37, 9, 2);
`ifdef SAD_MIN_THRESH_EN
        check("t6_below_37", below_thresh, 1);
`endif
        accept_result();
        check("t1_cleared", out_valid, 0);

        // Ties: lower mv_x within a row, earlier row across rows
        send_beat(mk(14'h3FFF, -1, 0));
        b = mk(14'h3FFF, 3, 10);
        b[12*SAD_W +: SAD_W] = 14'd10;
        send_beat(b);
        send_beat(mk(14'h3FFF, -1, 0));
        send_beat(mk(14'h3FFF, 0, 10));
        wait_out(lat);
        check_best("t2", 10, 3, 1);
        accept_result();

        // Backpressure: result held, input blocked
        send_beat(mk(200, -1, 0));
        send_beat(mk(200, 5, 100));
        send_beat(mk(200, -1, 0));
        send_beat(mk(200, -1, 0));
        wait_out(lat);
        check_best("t3a", 100, 5, 1);
        in_valid = 1'b1;
        sad_in   = mk(300, -1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t3_in_ready", in_ready, 0);
            check("t3_hold_sad", best_sad, 100);
        end
        check("t3_hold_mvx", best_mv_x, 5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("t3_released", out_valid, 0);
        send_beat(mk(300, -1, 0));
        send_beat(mk(300, -1, 0));
        send_beat(mk(300, 15, 7));
        wait_out(lat);
        check_best("t3b", 7, 15, 3);
        accept_result();

        // Mid-block flush; beat presented with flush is dropped
        out_ready = 1'b1;
        base = hs_cnt;
        send_beat(mk(5, -1, 0));
        send_beat(mk(5, -1, 0));
        flush    = 1'b1;
        in_valid = 1'b1;
        sad_in   = mk(1, -1, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        send_beat(mk(1000, 15, 0));
        send_beat(mk(1000, -1, 0));
        send_beat(mk(1000, -1, 0));
        send_beat(mk(1000, -1, 0));
        repeat (10) tick();
        check("t4_result_count", hs_cnt - base, 1);
        check("t4_sad", hs_sad, 0);
        check("t4_mvx", hs_x, 15);
        check("t4_mvy", hs_y, 0);

        // Asynchronous reset in block 3 of a stream
        base = hs_cnt;
        send_beat(mk(900, 1, 50));
        send_beat(mk(900, -1, 0));
        send_beat(mk(900, -1, 0));
        send_beat(mk(900, -1, 0));
        send_beat(mk(900, -1, 0));
        send_beat(mk(900, -1, 0));
        send_beat(mk(900, -1, 0));
        send_beat(mk(900, 7, 60));
        repeat (8) tick();
        check("t5_stream_count", hs_cnt - base, 2);
        check("t5_stream_sad", hs_sad, 60);
        check("t5_pre_rst_sad", best_sad, 60);
        send_beat(mk(20, -1, 0));
        send_beat(mk(20, -1, 0));
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_sad", best_sad, 0);
        check("t5_rst_mvx", best_mv_x, 0);
        check("t5_rst_mvy", best_mv_y, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        base = hs_cnt;
        send_beat(mk(800, -1, 0));
        send_beat(mk(800, -1, 0));
        repeat (8) tick();
        check("t5_no_partial", hs_cnt - base, 0);
        send_beat(mk(800, 4, 11));
        send_beat(mk(800, -1, 0));
        repeat (8) tick();
        check("t5_fresh_count", hs_cnt - base, 1);
        check("t5_fresh_sad", hs_sad, 11);
        check("t5_fresh_mvx", hs_x, 4);
        check("t5_fresh_mvy", hs_y, 2);
        out_ready = 1'b0;

`ifdef SAD_MIN_THRESH_EN
        // Threshold flag: 41 is above thresh=40
        send_beat(mk(500, -1, 0));
        send_beat(mk(500, 2, 41));
        send_beat(mk(500, -1, 0));
        send_beat(mk(500, -1, 0));
        wait_out(lat);
        check_best("t6", 41, 2, 1);
        check("t6_below_41", below_thresh, 0);
        accept_result();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
